// File: rtl/gfx128_pkg.sv
// Shared types and the lane result helper for the gfx128 interpolator.
// GFX_INTERP_ROUND_EN selects round-half-up in sat_shift; otherwise results are floored.
package gfx128_pkg;

  typedef enum logic [1:0] {CD_8 = 2'd0, CD_565 = 2'd1, CD_8888 = 2'd2} color_depth_e;

  localparam int INTERP_LATENCY = 3;
  localparam int SUM_W          = 64;

  // Drops the pw fraction bits of a weighted sum and clamps to a w-bit lane.
  function automatic logic [31:0] sat_shift(input logic signed [SUM_W-1:0] s,
                                            input int pw, input int w, input bit sgn);
    logic signed [SUM_W-1:0] t, hi, lo;
    t = s;
`ifdef GFX_INTERP_ROUND_EN
    t = t + (64'sd1 <<< (pw - 1));
`endif
    t  = t >>> pw;
    hi = sgn ? (64'sd1 <<< (w - 1)) - 64'sd1 : (64'sd1 <<< w) - 64'sd1;
    lo = sgn ? -(64'sd1 <<< (w - 1)) : 64'sd0;
    if (t > hi)      t = hi;
    else if (t < lo) t = lo;
    return t[31:0];
  endfunction

endpackage

// File: rtl/gfx128_interp_lane.sv
// One interpolated channel: S1 registers the three factor x vertex products,
// S2 registers the summed, shifted and saturated result.
module gfx128_interp_lane
  import gfx128_pkg::*;
#(
  parameter int PW     = 16,
  parameter int W      = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv,
  input  logic [2:0][PW:0]  f,
  input  logic [2:0][W-1:0] d,
  output logic [W-1:0]      q
);

  localparam int PRW = PW + W + 3;

  logic signed [PRW-1:0]   prod   [3];
  logic signed [PRW-1:0]   prod_d [3];
  logic signed [SUM_W-1:0] sum;

  // Factors are always non-negative; only the vertex value carries a sign.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      prod_d[i] = $signed({1'b0, f[i]}) * $signed({SIGNED & d[i][W-1], d[i]});
    end
  end

  assign sum = SUM_W'(prod[0]) + SUM_W'(prod[1]) + SUM_W'(prod[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) prod[i] <= '0;
      q <= '0;
    end else if (adv) begin
      for (int i = 0; i < 3; i++) prod[i] <= prod_d[i];
      q <= W'(sat_shift(sum, PW, W, SIGNED));
    end
  end

endmodule

// File: rtl/gfx128_interp_pipe.sv
// Barycentric interpolator: 3-stage valid/ready pipeline for colour, signed depth and attributes.
// Rounding follows GFX_INTERP_ROUND_EN (inside gfx128_pkg::sat_shift); default build truncates.
module gfx128_interp_pipe
  import gfx128_pkg::*;
#(
  parameter int POINT_WIDTH = 16,
  parameter int ATTR_WIDTH  = 16,
  parameter int NUM_ATTR    = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [POINT_WIDTH-1:0]              factor0_i,
  input  logic [POINT_WIDTH-1:0]              factor1_i,
  input  logic [POINT_WIDTH-1:0]              x_i,
  input  logic [POINT_WIDTH-1:0]              y_i,
  input  logic [1:0]                          color_depth_i,
  input  logic [31:0]                         color0_i,
  input  logic [31:0]                         color1_i,
  input  logic [31:0]                         color2_i,
  input  logic signed [POINT_WIDTH-1:0]       z0_i,
  input  logic signed [POINT_WIDTH-1:0]       z1_i,
  input  logic signed [POINT_WIDTH-1:0]       z2_i,
  input  logic [NUM_ATTR*ATTR_WIDTH-1:0]      attr0_i,
  input  logic [NUM_ATTR*ATTR_WIDTH-1:0]      attr1_i,
  input  logic [NUM_ATTR*ATTR_WIDTH-1:0]      attr2_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [POINT_WIDTH-1:0]              x_o,
  output logic [POINT_WIDTH-1:0]              y_o,
  output logic [31:0]                         color_o,
  output logic signed [POINT_WIDTH-1:0]       z_o,
  output logic [NUM_ATTR*ATTR_WIDTH-1:0]      attr_o,
  output logic [POINT_WIDTH-1:0]              bez0_o,
  output logic [POINT_WIDTH-1:0]              bez1_o,
  output logic                                busy_o
);

  localparam int PW = POINT_WIDTH;
  localparam int AW = ATTR_WIDTH;
  localparam int LW = NUM_ATTR * ATTR_WIDTH;

  logic                       adv;
  logic [INTERP_LATENCY-1:0]  vld_pipe;
  logic [PW:0]                fsum, f2_d;
  logic [2:0][PW:0]           f_s0;
  logic [1:0]                 cd_s0, cd_s1, cd_s2;
  logic [2:0][23:0]           col_s0;
  logic [2:0][PW-1:0]         z_s0;
  logic [2:0][LW-1:0]         attr_s0;
  logic [1:0][PW-1:0]         xy_s0, xy_s1, xy_s2;
  logic [1:0][PW-1:0]         bez_s1, bez_s2;
  logic [2:0][2:0][7:0]       cin;
  logic [2:0][7:0]            cq;

  assign adv         = ~vld_pipe[INTERP_LATENCY-1] | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = vld_pipe[INTERP_LATENCY-1];
  assign busy_o      = |vld_pipe;

  // f2 is the remainder of the unit weight; it clips at zero when f0+f1 already covers it.
  always_comb begin
    fsum = {1'b0, factor0_i} + {1'b0, factor1_i};
    f2_d = fsum[PW] ? '0 : {1'b1, {PW{1'b0}}} - fsum;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe <= '0;
      f_s0     <= '0;
      cd_s0    <= '0;
      cd_s1    <= '0;
      cd_s2    <= '0;
      col_s0   <= '0;
      z_s0     <= '0;
      attr_s0  <= '0;
      xy_s0    <= '0;
      xy_s1    <= '0;
      xy_s2    <= '0;
      bez_s1   <= '0;
      bez_s2   <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[INTERP_LATENCY-2:0], in_valid_i};
      f_s0      <= {f2_d, {1'b0, factor1_i}, {1'b0, factor0_i}};
      cd_s0     <= color_depth_i;
      col_s0    <= {color2_i[23:0], color1_i[23:0], color0_i[23:0]};
      z_s0      <= {z2_i, z1_i, z0_i};
      attr_s0   <= {attr2_i, attr1_i, attr0_i};
      xy_s0     <= {y_i, x_i};
      cd_s1     <= cd_s0;
      xy_s1     <= xy_s0;
      bez_s1[0] <= PW'((f_s0[1] >> 1) + f_s0[2]);
      bez_s1[1] <= f_s0[2][PW-1:0];
      cd_s2     <= cd_s1;
      xy_s2     <= xy_s1;
      bez_s2    <= bez_s1;
    end
  end

  // Channel index 2/1/0 = r/g/b; 565 fields stay right-aligned in 8-bit lanes.
  always_comb begin
    cin = '0;
    for (int v = 0; v < 3; v++) begin
      case (cd_s0)
        CD_8: begin
          cin[2][v] = col_s0[v][7:0];
          cin[1][v] = col_s0[v][7:0];
          cin[0][v] = col_s0[v][7:0];
        end
        CD_565: begin
          cin[2][v] = {3'b0, col_s0[v][15:11]};
          cin[1][v] = {2'b0, col_s0[v][10:5]};
          cin[0][v] = {3'b0, col_s0[v][4:0]};
        end
        default: begin
          cin[2][v] = col_s0[v][23:16];
          cin[1][v] = col_s0[v][15:8];
          cin[0][v] = col_s0[v][7:0];
        end
      endcase
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_col
    gfx128_interp_lane #(.PW(PW), .W(8), .SIGNED(1'b0)) u_lane (
      .clk(clk_i), .rst_n(rst_ni), .adv(adv), .f(f_s0), .d(cin[c]), .q(cq[c])
    );
  end

  gfx128_interp_lane #(.PW(PW), .W(PW), .SIGNED(1'b1)) u_z (
    .clk(clk_i), .rst_n(rst_ni), .adv(adv), .f(f_s0), .d(z_s0), .q(z_o)
  );

  for (genvar k = 0; k < NUM_ATTR; k++) begin : g_attr
    logic [2:0][AW-1:0] ad;
    for (genvar v = 0; v < 3; v++) begin : g_v
      assign ad[v] = attr_s0[v][k*AW +: AW];
    end
    gfx128_interp_lane #(.PW(PW), .W(AW), .SIGNED(1'b0)) u_lane (
      .clk(clk_i), .rst_n(rst_ni), .adv(adv), .f(f_s0), .d(ad), .q(attr_o[k*AW +: AW])
    );
  end

  // 565 channels can exceed their field when f0+f1 > unit, so clamp before packing.
  always_comb begin
    color_o = '0;
    case (cd_s2)
      CD_8:    color_o[7:0]  = cq[2];
      CD_565:  color_o[15:0] = {(cq[2] > 8'd31) ? 5'h1f : cq[2][4:0],
                                (cq[1] > 8'd63) ? 6'h3f : cq[1][5:0],
                                (cq[0] > 8'd31) ? 5'h1f : cq[0][4:0]};
      default: color_o[23:0] = {cq[2], cq[1], cq[0]};
    endcase
  end

  assign x_o    = xy_s2[0];
  assign y_o    = xy_s2[1];
  assign bez0_o = bez_s2[0];
  assign bez1_o = bez_s2[1];

endmodule

// File: tb/tb_gfx128_interp_pipe.sv
// Randomised and directed checks of gfx128_interp_pipe against an arithmetic reference model.
module tb_gfx128_interp_pipe;

  logic clk_i = 1'b0, rst_ni = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic in_ready_o, out_valid_o, busy_o;
  logic [15:0] factor0_i, factor1_i, x_i, y_i, x_o, y_o, bez0_o, bez1_o;
  logic [1:0]  color_depth_i;
  logic [31:0] color0_i, color1_i, color2_i, color_o;
  logic signed [15:0] z0_i, z1_i, z2_i, z_o;
  logic [63:0] attr0_i, attr1_i, attr2_i, attr_o;

  gfx128_interp_pipe #(.POINT_WIDTH(16), .ATTR_WIDTH(16), .NUM_ATTR(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .factor0_i(factor0_i), .factor1_i(factor1_i), .x_i(x_i), .y_i(y_i),
    .color_depth_i(color_depth_i), .color0_i(color0_i), .color1_i(color1_i), .color2_i(color2_i),
    .z0_i(z0_i), .z1_i(z1_i), .z2_i(z2_i), .attr0_i(attr0_i), .attr1_i(attr1_i), .attr2_i(attr2_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .x_o(x_o), .y_o(y_o),
    .color_o(color_o), .z_o(z_o), .attr_o(attr_o), .bez0_o(bez0_o), .bez1_o(bez1_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] f0, f1, x, y;
    logic [1:0]  cd;
    logic [2:0][31:0] c;
    logic [2:0][15:0] z;
    logic [2:0][63:0] a;
  } frag_t;

  typedef struct packed {
    logic [31:0] color;
    logic [15:0] z, x, y, b0, b1;
    logic [63:0] attr;
    logic [31:0] acc, st;
  } exp_t;

  frag_t stim[$];
  exp_t  exp_q[$];
  int total = 0, bad = 0;
  int cyc = 0, stall_cnt = 0, pops = 0, vld_pct = 100;
  bit head_seen = 1'b0, rdy = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Weighted sum of three vertices in 1/65536 units, floored (or rounded), clamped to w bits.
  function automatic longint lerp(input longint f0, f1, f2, d0, d1, d2, input int w, input bit sgn);
    longint s, hi, lo;
    s = f0 * d0 + f1 * d1 + f2 * d2;
`ifdef GFX_INTERP_ROUND_EN
    s = s + 32768;
`endif
    s  = (s >= 0) ? s / 65536 : -((65535 - s) / 65536);
    hi = sgn ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = sgn ? -(longint'(1) << (w - 1)) : 0;
    if (s > hi) s = hi;
    if (s < lo) s = lo;
    return s;
  endfunction

  function automatic exp_t model(input frag_t fr);
    exp_t e;
    longint f0, f1, f2;
    longint ch[3][3];
    longint mx[3];
    longint r[3];
    logic [31:0] c;
    e  = '0;
    f0 = longint'(fr.f0);
    f1 = longint'(fr.f1);
    f2 = (f0 + f1 >= 65536) ? 0 : 65536 - f0 - f1;
    for (int v = 0; v < 3; v++) begin
      c = fr.c[v];
      case (fr.cd)
        2'd0:    begin ch[v][0] = c[7:0];   ch[v][1] = c[7:0];  ch[v][2] = c[7:0]; end
        2'd1:    begin ch[v][0] = c[15:11]; ch[v][1] = c[10:5]; ch[v][2] = c[4:0]; end
        default: begin ch[v][0] = c[23:16]; ch[v][1] = c[15:8]; ch[v][2] = c[7:0]; end
      endcase
    end
    if (fr.cd == 2'd1) begin mx[0] = 31; mx[1] = 63; mx[2] = 31; end
    else begin mx[0] = 255; mx[1] = 255; mx[2] = 255; end
    for (int k = 0; k < 3; k++) begin
      r[k] = lerp(f0, f1, f2, ch[0][k], ch[1][k], ch[2][k], 8, 1'b0);
      if (r[k] > mx[k]) r[k] = mx[k];
    end
    case (fr.cd)
      2'd0:    e.color = 32'(r[0]);
      2'd1:    e.color = 32'((r[0] << 11) | (r[1] << 5) | r[2]);
      default: e.color = 32'((r[0] << 16) | (r[1] << 8) | r[2]);
    endcase
    e.z = 16'(lerp(f0, f1, f2, longint'($signed(fr.z[0])), longint'($signed(fr.z[1])),
                   longint'($signed(fr.z[2])), 16, 1'b1));
    for (int k = 0; k < 4; k++)
      e.attr[k*16 +: 16] = 16'(lerp(f0, f1, f2, longint'(fr.a[0][k*16 +: 16]),
                                    longint'(fr.a[1][k*16 +: 16]), longint'(fr.a[2][k*16 +: 16]), 16, 1'b0));
    e.b0 = 16'((f1 >> 1) + f2);
    e.b1 = 16'(f2);
    e.x  = fr.x;
    e.y  = fr.y;
    return e;
  endfunction

  function automatic frag_t rnd_frag();
    frag_t fr;
    fr.f0 = 16'($urandom);
    fr.f1 = 16'($urandom);
    if ($urandom_range(1) == 1) fr.f1 = 16'($urandom_range(65535 - int'(fr.f0)));
    fr.x  = 16'($urandom);
    fr.y  = 16'($urandom);
    fr.cd = 2'($urandom);
    for (int v = 0; v < 3; v++) begin
      fr.c[v] = $urandom;
      fr.z[v] = 16'($urandom);
      fr.a[v] = {$urandom, $urandom};
    end
    return fr;
  endfunction

  task automatic drive(input frag_t fr);
    factor0_i = fr.f0;  factor1_i = fr.f1;  x_i = fr.x;  y_i = fr.y;
    color_depth_i = fr.cd;
    color0_i = fr.c[0]; color1_i = fr.c[1]; color2_i = fr.c[2];
    z0_i = fr.z[0];     z1_i = fr.z[1];     z2_i = fr.z[2];
    attr0_i = fr.a[0];  attr1_i = fr.a[1];  attr2_i = fr.a[2];
  endtask

  // One clock: drive at the falling edge, settle, then check outputs and account the handshake.
  task automatic step();
    bit   go;
    exp_t e;
    @(negedge clk_i);
    go = (stim.size() > 0) && ($urandom_range(99) < vld_pct);
    in_valid_i = go;
    if (go) drive(stim[0]);
    out_ready_i = rdy;
    #1;
    check("busy", busy_o, exp_q.size() > 0);
    if (out_valid_o) begin
      if (exp_q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = exp_q[0];
        if (!head_seen) check("latency", cyc, e.acc + 3 + (stall_cnt - e.st));
        head_seen = 1'b1;
        check("color", color_o, e.color);
        check("z", $unsigned(z_o), e.z);
        check("attr", attr_o, e.attr);
        check("xy", {x_o, y_o}, {e.x, e.y});
        check("bez", {bez0_o, bez1_o}, {e.b0, e.b1});
        if (out_ready_i) begin
          void'(exp_q.pop_front());
          head_seen = 1'b0;
          pops++;
        end
      end
    end
    check("in_ready", in_ready_o, !(out_valid_o && !out_ready_i));
    if (in_valid_i && in_ready_o) begin
      e = model(stim[0]);
      e.acc = cyc;
      e.st  = stall_cnt;
      exp_q.push_back(e);
      void'(stim.pop_front());
    end
    if (out_valid_o && !out_ready_i) stall_cnt++;
    cyc++;
  endtask

  task automatic drain();
    rdy = 1'b1;
    vld_pct = 100;
    for (int i = 0; i < 300 && (stim.size() > 0 || exp_q.size() > 0); i++) step();
    check("drain_left", stim.size() + exp_q.size(), 0);
  endtask

  // Leaves the DUT outputs showing the fragment's result (or flags a timeout).
  task automatic run_one(input frag_t fr);
    bit seen;
    seen = 1'b0;
    drain();
    stim.push_back(fr);
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = out_valid_o;
    end
    if (!seen) check("run_one_timeout", 0, 1);
  endtask

  initial begin
    frag_t fr;
    int p0, stalled;
    drive('0);
    repeat (2) @(negedge clk_i);
    #1;
    check("rst_valid", out_valid_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_data", {color_o, x_o, y_o, bez0_o, bez1_o}, 0);
    check("rst_z_attr", {$unsigned(z_o), attr_o[47:0]}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("rst_ready", in_ready_o, 1);

    // Mid blend, 8888
    fr = '0; fr.cd = 2'd2; fr.f0 = 16'h8000; fr.f1 = 16'h8000;
    fr.c[0] = 32'h00FF0000; fr.c[1] = 32'h000000FF; fr.c[2] = 32'h12345678;
    run_one(fr);
`ifdef GFX_INTERP_ROUND_EN
    check("t1_color", color_o, 32'h00800080);
`else
    check("t1_color", color_o, 32'h007F007F);
`endif
    check("t1_bez", {bez0_o, bez1_o}, {16'h4000, 16'h0000});

    // Signed depth
    fr = '0; fr.f0 = 16'h4000; fr.z[0] = 16'hFF9C; fr.z[2] = 16'd100;
    run_one(fr);
    check("t2_z50", $unsigned(z_o), 16'd50);
    fr = '0; fr.f0 = 16'h8000; fr.f1 = 16'h8000; fr.z[0] = 16'hFF9C; fr.z[1] = 16'd100;
    run_one(fr);
    check("t2_z0", $unsigned(z_o), 16'd0);

    // 565 corner and factor overflow saturation
    fr = '0; fr.cd = 2'd1; fr.f0 = 16'hFFFF; fr.c[0] = 32'hF800; fr.c[2] = 32'hF800;
    run_one(fr);
    check("t3_565", color_o, 32'h0000F800);
    check("t3_f2", bez1_o, 16'd1);
    fr = '0; fr.f0 = 16'hC000; fr.f1 = 16'hC000;
    for (int v = 0; v < 3; v++) fr.a[v] = '1;
    run_one(fr);
    check("t3_attr_sat", attr_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("t3_f2_zero", bez1_o, 16'd0);

    // Back-pressure: hold ready low for 5 cycles once 3 results have left
    drain();
    for (int i = 0; i < 10; i++) stim.push_back(rnd_frag());
    p0 = pops;
    stalled = 0;
    for (int i = 0; i < 80 && (stim.size() > 0 || exp_q.size() > 0); i++) begin
      rdy = !((pops - p0) >= 3 && stalled < 5);
      step();
      if (!rdy) stalled++;
    end
    rdy = 1'b1;
    check("bp_count", pops - p0, 10);

    // Throughput: 20 back-to-back fragments leave in 23 cycles
    drain();
    for (int i = 0; i < 20; i++) stim.push_back(rnd_frag());
    p0 = pops;
    repeat (23) step();
    check("tput_count", pops - p0, 20);

    // Reset with 3 fragments in flight
    drain();
    for (int i = 0; i < 3; i++) stim.push_back(rnd_frag());
    repeat (3) step();
    @(negedge clk_i);
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("rst_mid_valid", out_valid_o, 0);
    check("rst_mid_busy", busy_o, 0);
    exp_q.delete();
    stim.delete();
    head_seen = 1'b0;
    repeat (2) step();
    @(negedge clk_i);
    rst_ni = 1'b1;
    p0 = pops;
    repeat (6) step();
    check("post_rst_quiet", pops - p0, 0);
    run_one(rnd_frag());

    // Random traffic with random stalls and input gaps
    drain();
    for (int i = 0; i < 300; i++) stim.push_back(rnd_frag());
    vld_pct = 70;
    for (int i = 0; i < 3000 && (stim.size() > 0 || exp_q.size() > 0); i++) begin
      rdy = ($urandom_range(3) != 0);
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
